// File: rtl/operand_fetch.sv
// Operand fetch: register file with write-back bypass feeding a registered ALU operand stage.
// Latency 1 cycle accept-to-output; holds outputs while Ex_ready=0 and deasserts Instr_ready.
module operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           Instr,
    input  logic                  Instr_valid,
    output logic                  Instr_ready,
    input  logic                  ALUSrc,
    input  logic [CTRL_WIDTH-1:0] ALUControl_in,
    input  logic                  WB_RegWrite,
    input  logic [ADDR_WIDTH-1:0] WB_Addr,
    input  logic [DATA_WIDTH-1:0] WB_Data,
    input  logic                  Ex_ready,
    output logic                  Ex_valid,
    output logic [DATA_WIDTH-1:0] SrcA,
    output logic [DATA_WIDTH-1:0] SrcB,
    output logic [CTRL_WIDTH-1:0] ALUControl
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic                  r_ex_valid;
    logic [DATA_WIDTH-1:0] r_src_a;
    logic [DATA_WIDTH-1:0] r_src_b;
    logic [CTRL_WIDTH-1:0] r_alu_ctrl;

    logic                  w_wb_en;
    logic [ADDR_WIDTH-1:0] w_rs_addr;
    logic [ADDR_WIDTH-1:0] w_rt_addr;
    logic [DATA_WIDTH-1:0] w_rs_dat;
    logic [DATA_WIDTH-1:0] w_rt_dat;
    logic [DATA_WIDTH-1:0] w_imm_ext;
    logic [DATA_WIDTH-1:0] w_op_b;
    logic                  w_accept;
    logic                  w_unused_opcode;

    assign w_wb_en         = WB_RegWrite && (WB_Addr != '0);
    assign w_rs_addr       = ADDR_WIDTH'(Instr[25:21]);
    assign w_rt_addr       = ADDR_WIDTH'(Instr[20:16]);
    assign w_imm_ext       = {{(DATA_WIDTH-16){Instr[15]}}, Instr[15:0]};
    assign w_unused_opcode = &Instr[31:26];

    // Entry 0 is hard-wired to zero on read, so a write-back to it can never bypass.
    always_comb begin
        w_rs_dat = '0;
        w_rt_dat = '0;
        if (w_rs_addr != '0)
            w_rs_dat = (w_wb_en && WB_Addr == w_rs_addr) ? WB_Data : r_regs[w_rs_addr];
        if (w_rt_addr != '0)
            w_rt_dat = (w_wb_en && WB_Addr == w_rt_addr) ? WB_Data : r_regs[w_rt_addr];
    end

    assign w_op_b      = ALUSrc ? w_imm_ext : w_rt_dat;
    assign Instr_ready = !r_ex_valid || Ex_ready;
    assign w_accept    = Instr_valid && Instr_ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
        end else if (w_wb_en) begin
            r_regs[WB_Addr] <= WB_Data;
        end
    end

    // Operands are captured only on accept, so register writes during a stall cannot leak in.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ex_valid <= 1'b0;
            r_src_a    <= '0;
            r_src_b    <= '0;
            r_alu_ctrl <= '0;
        end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_src_a    <= w_rs_dat;
            r_src_b    <= w_op_b;
            r_alu_ctrl <= ALUControl_in;
        end else if (Ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign Ex_valid   = r_ex_valid;
    assign SrcA       = r_src_a;
    assign SrcB       = r_src_b;
    assign ALUControl = r_alu_ctrl;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand and register width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, giving the register address width (2**ADDR_WIDTH entries).
REQ-003 The block SHALL have parameter CTRL_WIDTH, default 3, giving the ALU control width.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port Instr, input, 32 bits: instruction; rs=[25:21], rt=[20:16], imm=[15:0].
REQ-007 The block SHALL have port Instr_valid, input, 1 bit: upstream holds a valid instruction.
REQ-008 The block SHALL have port Instr_ready, output, 1 bit: the block accepts Instr this cycle.
REQ-009 The block SHALL have port ALUSrc, input, 1 bit: 1 selects the sign-extended immediate for SrcB.
REQ-010 The block SHALL have port ALUControl_in, input, CTRL_WIDTH bits: operation to forward.
REQ-011 The block SHALL have port WB_RegWrite, input, 1 bit: write-back enable.
REQ-012 The block SHALL have port WB_Addr, input, ADDR_WIDTH bits: write-back register address.
REQ-013 The block SHALL have port WB_Data, input, DATA_WIDTH bits: write-back data.
REQ-014 The block SHALL have port Ex_ready, input, 1 bit: the ALU stage consumes the outputs this cycle.
REQ-015 The block SHALL have port Ex_valid, output, 1 bit: SrcA, SrcB and ALUControl hold a valid operation.
REQ-016 The block SHALL have port SrcA, output, DATA_WIDTH bits: registered ALU operand A.
REQ-017 The block SHALL have port SrcB, output, DATA_WIDTH bits: registered ALU operand B.
REQ-018 The block SHALL have port ALUControl, output, CTRL_WIDTH bits: registered ALU operation.

Function
REQ-019 The block SHALL contain a 2**ADDR_WIDTH x DATA_WIDTH register file; entry 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-020 When WB_RegWrite=1 and WB_Addr!=0, the block SHALL write WB_Data into entry WB_Addr at the rising edge, independent of handshake state.
REQ-021 Reads of rs/rt SHALL be combinational with write-back bypass: if WB_RegWrite=1, WB_Addr!=0 and WB_Addr equals the read address, the read SHALL return WB_Data.
REQ-022 The immediate SHALL be sign-extended from bit 15 to DATA_WIDTH; operand B SHALL be that value when ALUSrc=1, else the rt read.
REQ-023 Instr_ready SHALL equal (!Ex_valid || Ex_ready), combinationally.
REQ-024 On an accept (Instr_valid && Instr_ready), the block SHALL load SrcA=rs read, SrcB=operand B and ALUControl=ALUControl_in, and set Ex_valid=1; latency is exactly one cycle.
REQ-025 When Ex_valid=1, Ex_ready=1 and there is no accept, Ex_valid SHALL clear; SrcA/SrcB/ALUControl SHALL keep their last values.
REQ-026 While Ex_valid=1 and Ex_ready=0 (stall), SrcA, SrcB, ALUControl and Ex_valid SHALL hold stable, and a register-file write SHALL NOT alter the held operands.
REQ-027 On a simultaneous consume and accept, the new operation SHALL replace the old one with no bubble (Ex_valid stays 1), sustaining one operation per cycle.
REQ-028 Instr and ALUSrc SHALL be ignored when Instr_valid=0.

Reset
REQ-029 While RST=0, the block SHALL drive Ex_valid=0, SrcA=0, SrcB=0 and ALUControl=0, and clear every register-file entry to 0, asynchronously.
REQ-030 A reset asserted mid-stall SHALL discard the held operation; after release, Instr_ready SHALL be 1 and the first accept SHALL behave as REQ-024.

Verification
REQ-031 The bench SHALL write WB_Addr=5, WB_Data=0x0000_0007, then accept rs=5, rt=0, ALUSrc=0, ALUControl_in=3'b010 -> next cycle Ex_valid=1, SrcA=7, SrcB=0, ALUControl=3'b010.
REQ-032 The bench SHALL accept ALUSrc=1 with imm=0xFFFC -> SrcB=0xFFFF_FFFC; with imm=0x7FFF -> SrcB=0x0000_7FFF.
REQ-033 The bench SHALL drive the same-cycle write WB_Addr=9, WB_Data=0x1234 with an accept of rs=9 -> SrcA=0x1234 (bypass); a write to WB_Addr=0 with data 0xFFFF followed by rs=0 -> SrcA=0.
REQ-034 The bench SHALL hold Ex_ready=0 for 3 cycles after an accept while writing the source register -> Instr_ready=0, and outputs unchanged for all 3 cycles.
REQ-035 The bench SHALL run back-to-back accepts with Ex_ready=1 for 4 cycles -> 4 consecutive Ex_valid=1 cycles with the operand sequence in order.
REQ-036 The bench SHALL assert RST=0 during a stall -> Ex_valid=0 and SrcA=SrcB=0 immediately; after release, a read of any register returns 0.
